// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank
// AXI4-Lite slave exposing eight 32-bit word registers to a UART-driven host:
//   word 0 : constant ID (read-only)
//   word 1 : synchronized status_in (read-only)
//   word 2..7 : control words driven on ctrl_out, byte-maskable, with a
//               one-cycle wr_pulse per register on every accepted write.
// The AW and W channels are captured independently into holding registers and
// committed together once both are present; reads are fully independent.

module axi_lite_regbank #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] ID_VALUE           = 32'h5541_5254
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  // write address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  // write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  // write response channel
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  // read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  // read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  // fabric side
  input  logic [31:0]                       status_in,
  output logic [191:0]                      ctrl_out,
  output logic [5:0]                        wr_pulse
);

  localparam int         NUM_CTRL   = 6;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Short local names for the clock and reset.
  logic clk;
  logic rst_n;
  assign clk   = s00_axi_aclk;
  assign rst_n = s00_axi_aresetn;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                      run;          // low in reset and the first cycle after
  logic                      aw_held;      // an accepted AW awaits its W
  logic                      w_held;       // an accepted W awaits its AW
  logic [2:0]                aw_idx;       // word index of the held write address
  logic [31:0]               w_data;       // held write data
  logic [3:0]                w_strb;       // held byte strobes
  logic [NUM_CTRL-1:0][31:0] ctrl_q;       // control words 2..7 (entry 0 is word 2)
  logic [31:0]               status_meta;  // first synchronizer stage
  logic [31:0]               status_sync;  // second synchronizer stage, read back
  logic                      bvalid_q;
  logic [1:0]                bresp_q;
  logic                      rvalid_q;
  logic [1:0]                rresp_q;
  logic [31:0]               rdata_q;
  logic [NUM_CTRL-1:0]       wr_pulse_q;

  // ---------------------------------------------------------------------------
  // Handshake and commit qualifiers
  // ---------------------------------------------------------------------------
  logic       aw_hs;
  logic       w_hs;
  logic       ar_hs;
  logic       commit;
  logic       commit_ctrl;
  logic [2:0] ctrl_sel;

  assign s00_axi_awready = run & ~aw_held & ~bvalid_q;
  assign s00_axi_wready  = run & ~w_held  & ~bvalid_q;
  assign s00_axi_arready = run & ~rvalid_q;

  assign aw_hs  = s00_axi_awvalid & s00_axi_awready;
  assign w_hs   = s00_axi_wvalid  & s00_axi_wready;
  assign ar_hs  = s00_axi_arvalid & s00_axi_arready;

  // Both halves present and the previous response has been taken.
  assign commit      = aw_held & w_held & ~bvalid_q;
  assign commit_ctrl = commit & (aw_idx >= 3'd2);
  assign ctrl_sel    = aw_idx - 3'd2;

  // ---------------------------------------------------------------------------
  // Run flag: releases the handshakes one cycle after reset deasserts, so the
  // async reset release never races an incoming valid.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always assigned with <= so every flop samples the
  // pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Write address / data capture; holding flags clear on commit.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= s00_axi_awaddr[4:2];
      end else if (commit) begin
        aw_held <= 1'b0;
      end

      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= s00_axi_wdata[31:0];
        w_strb <= s00_axi_wstrb[3:0];
      end else if (commit) begin
        w_held <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write response: raised on commit, held stable until bready.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= (aw_idx >= 3'd2) ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && s00_axi_bready) begin
      bvalid_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers: byte-lane update of the addressed word on commit.
  // ---------------------------------------------------------------------------
  // NOTE: this register file is only six words, so it is reset like any other
  // state; fabric logic sees a defined all-zero control word out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else if (commit_ctrl) begin
      for (int k = 0; k < NUM_CTRL; k++) begin
        if (ctrl_sel == 3'(k)) begin
          for (int b = 0; b < 4; b++) begin
            if (w_strb[b]) ctrl_q[k][8*b +: 8] <= w_data[8*b +: 8];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write pulse: one cycle, coincident with the updated ctrl_out value. A
  // control write with all strobes low still pulses.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pulse_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CTRL; k++) begin
        wr_pulse_q[k] <= commit_ctrl && (ctrl_sel == 3'(k));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous status word.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_meta <= '0;
      status_sync <= '0;
    end else begin
      status_meta <= status_in;
      status_sync <= status_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux on the incoming read address.
  // ---------------------------------------------------------------------------
  logic [31:0] rd_mux;

  // NOTE: every always_comb output gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    rd_mux = '0;
    unique case (s00_axi_araddr[4:2])
      3'd0: rd_mux = ID_VALUE;
      3'd1: rd_mux = status_sync;
      3'd2: rd_mux = ctrl_q[0];
      3'd3: rd_mux = ctrl_q[1];
      3'd4: rd_mux = ctrl_q[2];
      3'd5: rd_mux = ctrl_q[3];
      3'd6: rd_mux = ctrl_q[4];
      3'd7: rd_mux = ctrl_q[5];
      default: rd_mux = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read data channel: capture on AR handshake, hold stable until rready.
  // A commit on the same edge is not visible to this capture.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= rd_mux;
    end else if (rvalid_q && s00_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s00_axi_bvalid = bvalid_q;
  assign s00_axi_bresp  = bresp_q;
  assign s00_axi_rvalid = rvalid_q;
  assign s00_axi_rresp  = rresp_q;
  assign s00_axi_rdata  = C_S_AXI_DATA_WIDTH'(rdata_q);
  assign ctrl_out       = ctrl_q;
  assign wr_pulse       = wr_pulse_q;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Testbench for axi_lite_regbank.
// Stimulus tasks push the expected B/R responses into queues; a monitor on the
// falling edge pops and compares whenever a response handshake is presented.
// Direct checks cover reset values, ctrl_out, wr_pulse and hold behaviour.

module tb_axi_lite_regbank;

  logic         clk;
  logic         rst_n;
  logic [4:0]   awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [4:0]   araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [31:0]  status_in;
  logic [191:0] ctrl_out;
  logic [5:0]   wr_pulse;

  axi_lite_regbank dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .status_in       (status_in),
    .ctrl_out        (ctrl_out),
    .wr_pulse        (wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rsp_t;

  logic [1:0] b_q[$];
  rsp_t       r_q[$];
  logic [1:0] exp_b;
  rsp_t       exp_r;
  logic [191:0] exp_ctrl;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compare each presented response at its handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bvalid && bready) begin
        if (b_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected: got bresp %0h with nothing expected", bresp);
        end else begin
          exp_b = b_q.pop_front();
          check("bresp", {190'd0, bresp}, {190'd0, exp_b});
        end
      end
      if (rvalid && rready) begin
        if (r_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL r_unexpected: got rdata %0h with nothing expected", rdata);
        end else begin
          exp_r = r_q.pop_front();
          check("rdata", {160'd0, rdata}, {160'd0, exp_r.data});
          check("rresp", {190'd0, rresp}, {190'd0, exp_r.resp});
        end
      end
    end
  end

  // Drive AW and/or W until each is accepted; returns just after the last
  // accepting edge.
  task automatic send_aw_w(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit do_aw, input bit do_w);
    bit aw_ok;
    bit w_ok;
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    awvalid = do_aw;
    wvalid  = do_w;
    for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
      @(negedge clk);
      aw_ok = awvalid && awready;
      w_ok  = wvalid && wready;
      @(posedge clk);
      #1;
      if (aw_ok) awvalid = 1'b0;
      if (w_ok)  wvalid  = 1'b0;
    end
    if (awvalid || wvalid) begin
      checks++;
      errors++;
      $display("FAIL aw_w_timeout: got awvalid=%0b wvalid=%0b still pending, required accepted", awvalid, wvalid);
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end
  endtask

  task automatic send_ar(input logic [4:0] addr);
    bit ar_ok;
    araddr  = addr;
    arvalid = 1'b1;
    for (int i = 0; i < 20 && arvalid; i++) begin
      @(negedge clk);
      ar_ok = arready;
      @(posedge clk);
      #1;
      if (ar_ok) arvalid = 1'b0;
    end
    if (arvalid) begin
      checks++;
      errors++;
      $display("FAIL ar_timeout: got arvalid still pending, required accepted");
      arvalid = 1'b0;
    end
  endtask

  task automatic wait_b_done();
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bvalid && bready) done = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL b_timeout: got no write response, required one");
    end
  endtask

  task automatic wait_r_done();
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (rvalid && rready) done = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL r_timeout: got no read response, required one");
    end
  endtask

  task automatic do_read(input logic [4:0] addr, input logic [31:0] exp);
    r_q.push_back('{data: exp, resp: 2'b00});
    send_ar(addr);
    wait_r_done();
  endtask

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    awaddr    = '0;
    awprot    = '0;
    awvalid   = 1'b0;
    wdata     = '0;
    wstrb     = '0;
    wvalid    = 1'b0;
    bready    = 1'b1;
    araddr    = '0;
    arprot    = '0;
    arvalid   = 1'b0;
    rready    = 1'b1;
    status_in = '0;
    exp_ctrl  = '0;

    // ---- Reset: outputs zero, readies held low until run rises ----
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_readies", {189'd0, awready, wready, arready}, 192'd0);
    check("rst_valids",  {190'd0, bvalid, rvalid}, 192'd0);
    check("rst_resps",   {188'd0, bresp, rresp}, 192'd0);
    check("rst_rdata",   {160'd0, rdata}, 192'd0);
    check("rst_ctrl",    ctrl_out, 192'd0);
    check("rst_pulse",   {186'd0, wr_pulse}, 192'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_readies_low", {189'd0, awready, wready, arready}, 192'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("run_readies_high", {189'd0, awready, wready, arready}, 192'd7);

    // ---- Simultaneous AW+W to word 2 ----
    b_q.push_back(2'b00);
    send_aw_w(5'h08, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1);
    @(posedge clk); #1;
    exp_ctrl[31:0] = 32'hDEAD_BEEF;
    check("w2_bvalid",   {191'd0, bvalid}, 192'd1);
    check("w2_pulse",    {186'd0, wr_pulse}, 192'd1);
    check("w2_ctrl",     ctrl_out, exp_ctrl);
    @(posedge clk); #1;
    check("w2_pulse_end", {186'd0, wr_pulse}, 192'd0);
    check("w2_bvalid_clr", {191'd0, bvalid}, 192'd0);
    do_read(5'h08, 32'hDEAD_BEEF);

    // ---- W three cycles ahead of AW, partial strobes, bready stalled ----
    bready = 1'b0;
    b_q.push_back(2'b00);
    send_aw_w(5'h1C, 32'h1122_3344, 4'b0101, 1'b0, 1'b1);
    check("w_held_readies", {190'd0, awready, wready}, 192'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    send_aw_w(5'h1C, 32'h0, 4'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    exp_ctrl[191:160] = 32'h0022_0044;
    check("w7_pulse", {186'd0, wr_pulse}, 192'h20);
    check("w7_ctrl",  ctrl_out, exp_ctrl);
    for (int i = 0; i < 4; i++) begin
      check("b_hold_valid",  {191'd0, bvalid}, 192'd1);
      check("b_hold_resp",   {190'd0, bresp}, 192'd0);
      check("b_hold_awready", {191'd0, awready}, 192'd0);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    wait_b_done();
    do_read(5'h1C, 32'h0022_0044);

    // ---- Writes to read-only words: SLVERR, no effect ----
    b_q.push_back(2'b10);
    send_aw_w(5'h00, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("ro0_bvalid", {191'd0, bvalid}, 192'd1);
    check("ro0_bresp",  {190'd0, bresp}, 192'd2);
    check("ro0_pulse",  {186'd0, wr_pulse}, 192'd0);
    check("ro0_ctrl",   ctrl_out, exp_ctrl);
    wait_b_done();
    do_read(5'h00, 32'h5541_5254);

    b_q.push_back(2'b10);
    send_aw_w(5'h04, 32'h1234_5678, 4'hF, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("ro1_pulse", {186'd0, wr_pulse}, 192'd0);
    wait_b_done();
    check("ro1_ctrl", ctrl_out, exp_ctrl);

    // ---- Zero-strobe write to word 4: OKAY, pulse, no data change ----
    b_q.push_back(2'b00);
    send_aw_w(5'h10, 32'hCAFE_F00D, 4'h0, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("strb0_pulse", {186'd0, wr_pulse}, 192'h04);
    check("strb0_ctrl",  ctrl_out, exp_ctrl);
    wait_b_done();

    // ---- Status synchronizer, rready stalled ----
    status_in = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rready = 1'b0;
    r_q.push_back('{data: 32'hA5A5_A5A5, resp: 2'b00});
    send_ar(5'h04);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check("r_hold_valid",   {191'd0, rvalid}, 192'd1);
      check("r_hold_data",    {160'd0, rdata}, {160'd0, 32'hA5A5_A5A5});
      check("r_hold_arready", {191'd0, arready}, 192'd0);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    wait_r_done();

    // ---- Read and commit to word 3 on the same edge ----
    b_q.push_back(2'b00);
    r_q.push_back('{data: 32'h0, resp: 2'b00});
    awaddr  = 5'h0C;
    wdata   = 32'h0000_0001;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    @(negedge clk);
    check("same_aw_w_ready", {190'd0, awready, wready}, 192'd3);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    araddr  = 5'h0C;
    arvalid = 1'b1;
    @(negedge clk);
    check("same_arready", {191'd0, arready}, 192'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    exp_ctrl[63:32] = 32'h0000_0001;
    check("same_valids", {190'd0, bvalid, rvalid}, 192'd3);
    check("same_pulse",  {186'd0, wr_pulse}, 192'h02);
    check("same_ctrl",   ctrl_out, exp_ctrl);
    @(posedge clk); #1;
    check("same_valids_clr", {190'd0, bvalid, rvalid}, 192'd0);
    do_read(5'h0C, 32'h0000_0001);

    // ---- Drain ----
    repeat (3) @(posedge clk);
    #1;
    check("b_q_drained", 192'(b_q.size()), 192'd0);
    check("r_q_drained", 192'(r_q.size()), 192'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
